// File: rtl/zm_unpack_sequencer_if.sv
// -----------------------------------------------------------------------------
// zm_unpack_sequencer_if
// Bundles the handshake and bus signals of the Z-Modem receive unpack
// sequencer: frame configuration/status, block source stream, byte unpacker
// control/data and the downstream payload byte stream.
//   slave  : sequencer side (consumes cfg/blocks/unpacker bytes, drives payload)
//   master : environment side (drives cfg/blocks/unpacker, sinks payload)
// -----------------------------------------------------------------------------
interface zm_unpack_sequencer_if #(
   parameter int LEN_W = 16
);
   logic [LEN_W-1:0] cfg_len;
   logic             cfg_start;
   logic             busy;
   logic             done;
   logic [127:0]     s_blk_tdata;
   logic             s_blk_tvalid;
   logic             s_blk_tready;
   logic [127:0]     unp_plain_block;
   logic             unp_load_en;
   logic             unp_buffer_ready;
   logic [7:0]       unp_tdata;
   logic             unp_tvalid;
   logic             unp_tready;
   logic [7:0]       m_axis_tdata;
   logic             m_axis_tvalid;
   logic             m_axis_tready;
   logic             m_axis_tlast;

   modport slave (
      input  cfg_len, cfg_start, s_blk_tdata, s_blk_tvalid, unp_buffer_ready,
             unp_tdata, unp_tvalid, m_axis_tready,
      output busy, done, s_blk_tready, unp_plain_block, unp_load_en,
             unp_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
   );

   modport master (
      output cfg_len, cfg_start, s_blk_tdata, s_blk_tvalid, unp_buffer_ready,
             unp_tdata, unp_tvalid, m_axis_tready,
      input  busy, done, s_blk_tready, unp_plain_block, unp_load_en,
             unp_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
   );
endinterface

// File: rtl/zm_unpack_sequencer.sv
// -----------------------------------------------------------------------------
// zm_unpack_sequencer
// Sequences the receive-side byte unpacker for one Z-Modem payload frame:
// latches the frame length, fetches 128-bit blocks when the unpacker is empty,
// strobes each block into the unpacker, forwards payload bytes downstream with
// TLAST on the final byte, and drains the padding bytes of the last block.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   io         : zm_unpack_sequencer_if.slave (cfg/status, block stream,
//                unpacker control/data, payload byte stream)
// -----------------------------------------------------------------------------
module zm_unpack_sequencer #(
   parameter int LEN_W = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   zm_unpack_sequencer_if.slave  io
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WAIT_BLK = 3'd1,
      ST_LOAD     = 3'd2,
      ST_STREAM   = 3'd3,
      ST_DRAIN    = 3'd4,
      ST_DONE     = 3'd5
   } state_t;

   localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
   localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic [LEN_W-1:0] bytes_left_q, bytes_left_d;
   logic [3:0]       blk_cnt_q, blk_cnt_d;
   logic [127:0]     plain_q, plain_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             load_q, load_d;

   logic             blk_hs_s;
   logic             byte_xfer_s;
   logic             unp_tready_s;
   logic             m_tvalid_s;
   logic             m_tlast_s;

   // Blocks are only accepted while waiting and the unpacker buffer is empty.
   assign io.s_blk_tready = (state_q == ST_WAIT_BLK) & io.unp_buffer_ready;
   assign blk_hs_s        = io.s_blk_tvalid & io.s_blk_tready;

   // Byte path mux: pass-through while streaming, silent discard while draining.
   always_comb begin
      unp_tready_s = 1'b0;
      m_tvalid_s   = 1'b0;
      m_tlast_s    = 1'b0;
      case (state_q)
         ST_STREAM: begin
            unp_tready_s = io.m_axis_tready;
            m_tvalid_s   = io.unp_tvalid;
            m_tlast_s    = (bytes_left_q == LEN_ONE);
         end
         ST_DRAIN: begin
            unp_tready_s = 1'b1;
         end
         default: begin
            unp_tready_s = 1'b0;
         end
      endcase
   end

   assign byte_xfer_s      = io.unp_tvalid & unp_tready_s;
   assign io.unp_tready    = unp_tready_s;
   assign io.m_axis_tvalid = m_tvalid_s;
   assign io.m_axis_tlast  = m_tlast_s;
   assign io.m_axis_tdata  = io.unp_tdata;

   assign io.busy            = busy_q;
   assign io.done            = done_q;
   assign io.unp_load_en     = load_q;
   assign io.unp_plain_block = plain_q;

   // Next-state and datapath computation for the frame sequencer.
   always_comb begin
      state_d      = state_q;
      bytes_left_d = bytes_left_q;
      blk_cnt_d    = blk_cnt_q;
      plain_d      = plain_q;
      case (state_q)
         ST_IDLE: begin
            if (io.cfg_start) begin
               if (io.cfg_len != LEN_ZERO) begin
                  bytes_left_d = io.cfg_len;
                  blk_cnt_d    = 4'd0;
                  state_d      = ST_WAIT_BLK;
               end else begin
                  state_d      = ST_DONE;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT_BLK: begin
            if (blk_hs_s) begin
               plain_d = io.s_blk_tdata;
               state_d = ST_LOAD;
            end else begin
               state_d = ST_WAIT_BLK;
            end
         end
         ST_LOAD: begin
            blk_cnt_d = 4'd0;
            state_d   = ST_STREAM;
         end
         ST_STREAM: begin
            if (byte_xfer_s) begin
               // bytes_left saturates at zero
               if (bytes_left_q != LEN_ZERO) begin
                  bytes_left_d = bytes_left_q - LEN_ONE;
               end else begin
                  bytes_left_d = LEN_ZERO;
               end
               // blk_cnt holds at 15 here; the next LOAD clears it
               if (blk_cnt_q == 4'd15) begin
                  if (bytes_left_q == LEN_ONE) begin
                     state_d = ST_DONE;
                  end else begin
                     state_d = ST_WAIT_BLK;
                  end
               end else begin
                  blk_cnt_d = blk_cnt_q + 4'd1;
                  if (bytes_left_q == LEN_ONE) begin
                     state_d = ST_DRAIN;
                  end else begin
                     state_d = ST_STREAM;
                  end
               end
            end else begin
               state_d = ST_STREAM;
            end
         end
         ST_DRAIN: begin
            if (byte_xfer_s) begin
               if (blk_cnt_q == 4'd15) begin
                  state_d = ST_DONE;
               end else begin
                  blk_cnt_d = blk_cnt_q + 4'd1;
                  state_d   = ST_DRAIN;
               end
            end else begin
               state_d = ST_DRAIN;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Status strobes are registered copies of the state being entered.
      busy_d = (state_d == ST_WAIT_BLK) || (state_d == ST_LOAD) ||
               (state_d == ST_STREAM)   || (state_d == ST_DRAIN);
      done_d = (state_d == ST_DONE);
      load_d = (state_d == ST_LOAD);
   end

   // State and registered outputs, cleared asynchronously by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         bytes_left_q <= LEN_ZERO;
         blk_cnt_q    <= 4'd0;
         plain_q      <= 128'd0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         load_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         bytes_left_q <= bytes_left_d;
         blk_cnt_q    <= blk_cnt_d;
         plain_q      <= plain_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         load_q       <= load_d;
      end
   end

endmodule

// File: tb/tb_zm_unpack_sequencer.sv
// -----------------------------------------------------------------------------
// tb_zm_unpack_sequencer
// Directed bench: models the block source and the byte unpacker, records the
// payload stream and compares it with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_zm_unpack_sequencer;

   localparam int LEN_W = 16;

   logic clk = 1'b0;
   logic reset;

   zm_unpack_sequencer_if #(.LEN_W(LEN_W)) bus ();

   zm_unpack_sequencer #(.LEN_W(LEN_W)) dut (
      .clk   (clk),
      .reset (reset),
      .io    (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // environment model state
   logic [127:0] blk_q[$];
   int           blk_delay = 0;
   int           blk_wait  = 0;
   logic [127:0] unp_buf   = 128'd0;
   int           unp_cnt   = 0;
   int           unp_ptr   = 0;
   int           rdy_mode  = 0;
   int           rdy_phase = 0;

   // monitor state
   logic [7:0]   rx_data[$];
   int           tlast_cnt, last_pos, done_cnt, blk_pop_cnt;
   int           unp_xfer_cnt, s_rdy_cnt, load_cnt, load_bad;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] make_blk(input logic [7:0] base);
      logic [127:0] b;
      for (int i = 0; i < 16; i++) b[127-8*i -: 8] = 8'(base + 8'(i));
      return b;
   endfunction

   task automatic mon_clear();
      rx_data.delete();
      tlast_cnt = 0; last_pos = -1; done_cnt = 0; blk_pop_cnt = 0;
      unp_xfer_cnt = 0; s_rdy_cnt = 0; load_cnt = 0; load_bad = 0;
   endtask

   // Block source, byte unpacker and payload sink models.
   initial begin
      logic         fire_u, fire_b, do_load;
      logic [127:0] ld_blk;
      forever begin
         @(negedge clk);
         fire_u  = bus.unp_tvalid & bus.unp_tready;
         fire_b  = bus.s_blk_tvalid & bus.s_blk_tready;
         do_load = bus.unp_load_en;
         ld_blk  = bus.unp_plain_block;
         if (bus.m_axis_tvalid && bus.m_axis_tready) begin
            rx_data.push_back(bus.m_axis_tdata);
            if (bus.m_axis_tlast) begin
               tlast_cnt++;
               last_pos = rx_data.size() - 1;
            end
         end
         if (bus.done) done_cnt++;
         if (bus.s_blk_tready) s_rdy_cnt++;
         if (fire_u) unp_xfer_cnt++;
         if (fire_b) begin
            blk_pop_cnt++;
            if (!bus.unp_buffer_ready) load_bad++;
         end
         if (do_load) load_cnt++;
         @(posedge clk);
         #1;
         if (reset) begin
            unp_cnt = 0;
            unp_ptr = 0;
         end else begin
            if (do_load) begin
               unp_buf = ld_blk;
               unp_cnt = 16;
               unp_ptr = 0;
            end
            if (fire_u && unp_cnt > 0) begin
               unp_ptr++;
               unp_cnt--;
            end
            if (fire_b && blk_q.size() > 0) begin
               void'(blk_q.pop_front());
               blk_wait = blk_delay;
            end else if (blk_q.size() > 0 && blk_wait > 0) begin
               blk_wait--;
            end
         end
         bus.unp_tvalid       = (unp_cnt > 0);
         bus.unp_tdata        = (unp_cnt > 0) ? unp_buf[127-8*unp_ptr -: 8] : 8'h00;
         bus.unp_buffer_ready = (unp_cnt == 0);
         bus.s_blk_tvalid     = (blk_q.size() > 0) && (blk_wait == 0);
         bus.s_blk_tdata      = (blk_q.size() > 0) ? blk_q[0] : 128'd0;
         rdy_phase            = (rdy_phase + 1) % 3;
         bus.m_axis_tready    = (rdy_mode == 0) ? 1'b1 : (rdy_phase == 0);
      end
   end

   task automatic start_frame(input logic [15:0] len);
      bus.cfg_len   = len;
      bus.cfg_start = 1'b1;
      @(posedge clk);
      #1;
      bus.cfg_start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int c;
      for (c = 0; c < 3000 && done_cnt == 0; c++) begin
         @(posedge clk);
         #1;
      end
      chk({tag, "_timeout"}, 128'(done_cnt != 0), 128'(1));
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      chk({tag, "_busy_end"}, 128'(bus.busy), 128'(0));
      chk({tag, "_done_end"}, 128'(bus.done), 128'(0));
      chk({tag, "_done_cnt"}, 128'(done_cnt), 128'(1));
   endtask

   task automatic frame_check(input string tag, input int len, input logic [7:0] base,
                              input int nblk);
      logic [7:0] g;
      chk({tag, "_nbytes"}, 128'(rx_data.size()), 128'(len));
      for (int i = 0; i < len; i++) begin
         g = (i < rx_data.size()) ? rx_data[i] : 8'hxx;
         chk($sformatf("%s_byte%0d", tag, i), 128'(g), 128'(8'(base + 8'(i))));
      end
      chk({tag, "_tlast_cnt"}, 128'(tlast_cnt), 128'(1));
      chk({tag, "_tlast_pos"}, 128'(last_pos), 128'(len - 1));
      chk({tag, "_blk_pop"}, 128'(blk_pop_cnt), 128'(nblk));
      chk({tag, "_loads"}, 128'(load_cnt), 128'(nblk));
      chk({tag, "_load_bad"}, 128'(load_bad), 128'(0));
      chk({tag, "_unp_xfers"}, 128'(unp_xfer_cnt), 128'(16 * nblk));
   endtask

   initial begin
      reset                = 1'b1;
      bus.cfg_len          = 16'd0;
      bus.cfg_start        = 1'b0;
      bus.s_blk_tdata      = 128'd0;
      bus.s_blk_tvalid     = 1'b0;
      bus.unp_buffer_ready = 1'b1;
      bus.unp_tdata        = 8'h00;
      bus.unp_tvalid       = 1'b0;
      bus.m_axis_tready    = 1'b1;
      mon_clear();
      #1;
      chk("rst_busy", 128'(bus.busy), 128'(0));
      chk("rst_done", 128'(bus.done), 128'(0));
      chk("rst_s_blk_tready", 128'(bus.s_blk_tready), 128'(0));
      chk("rst_load_en", 128'(bus.unp_load_en), 128'(0));
      chk("rst_unp_tready", 128'(bus.unp_tready), 128'(0));
      chk("rst_m_tvalid", 128'(bus.m_axis_tvalid), 128'(0));
      chk("rst_m_tlast", 128'(bus.m_axis_tlast), 128'(0));
      chk("rst_plain_block", bus.unp_plain_block, 128'd0);
      #21;
      reset = 1'b0;
      @(posedge clk);
      #1;

      // T1: one full block, spare block must stay unconsumed
      mon_clear();
      blk_q.push_back(make_blk(8'h00));
      blk_q.push_back(make_blk(8'h10));
      start_frame(16'd16);
      chk("t1_busy_start", 128'(bus.busy), 128'(1));
      wait_done("t1");
      frame_check("t1", 16, 8'h00, 1);
      chk("t1_spare_left", 128'(blk_q.size()), 128'(1));
      blk_q.delete();
      repeat (3) begin
         @(posedge clk);
         #1;
      end

      // T2: 20 bytes over two blocks, 12 padding bytes drained
      mon_clear();
      blk_q.push_back(make_blk(8'h00));
      blk_q.push_back(make_blk(8'h10));
      start_frame(16'd20);
      wait_done("t2");
      frame_check("t2", 20, 8'h00, 2);

      // T3: zero-length frame, done in the cycle after start
      mon_clear();
      blk_q.push_back(make_blk(8'h20));
      start_frame(16'd0);
      chk("t3_done_lat", 128'(bus.done), 128'(1));
      chk("t3_busy", 128'(bus.busy), 128'(0));
      wait_done("t3");
      chk("t3_s_rdy_seen", 128'(s_rdy_cnt), 128'(0));
      chk("t3_nbytes", 128'(rx_data.size()), 128'(0));
      chk("t3_blk_pop", 128'(blk_pop_cnt), 128'(0));
      blk_q.delete();
      repeat (3) begin
         @(posedge clk);
         #1;
      end

      // T4: 32 bytes, sink 1-on/2-off, source delayed, start pulsed mid-frame
      mon_clear();
      rdy_mode  = 1;
      blk_delay = 5;
      blk_wait  = 5;
      blk_q.push_back(make_blk(8'h00));
      blk_q.push_back(make_blk(8'h10));
      start_frame(16'd32);
      repeat (10) begin
         @(posedge clk);
         #1;
      end
      start_frame(16'd5);
      wait_done("t4");
      frame_check("t4", 32, 8'h00, 2);
      rdy_mode  = 0;
      blk_delay = 0;
      blk_wait  = 0;

      // T5: 5-byte frame after done, 11 bytes drained
      mon_clear();
      blk_q.push_back(make_blk(8'h40));
      start_frame(16'd5);
      wait_done("t5");
      frame_check("t5", 5, 8'h40, 1);

      // T6: reset after byte 7 of a 16-byte frame, then a fresh frame
      mon_clear();
      blk_q.push_back(make_blk(8'h80));
      start_frame(16'd16);
      for (int c = 0; c < 200 && rx_data.size() < 7; c++) begin
         @(posedge clk);
         #1;
      end
      chk("t6_seven_bytes", 128'(rx_data.size()), 128'(7));
      chk("t6_pre_unp_tready", 128'(bus.unp_tready), 128'(1));
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("t6_busy", 128'(bus.busy), 128'(0));
      chk("t6_done", 128'(bus.done), 128'(0));
      chk("t6_s_blk_tready", 128'(bus.s_blk_tready), 128'(0));
      chk("t6_load_en", 128'(bus.unp_load_en), 128'(0));
      chk("t6_unp_tready", 128'(bus.unp_tready), 128'(0));
      chk("t6_m_tvalid", 128'(bus.m_axis_tvalid), 128'(0));
      chk("t6_m_tlast", 128'(bus.m_axis_tlast), 128'(0));
      chk("t6_plain_block", bus.unp_plain_block, 128'd0);
      blk_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      mon_clear();
      blk_q.push_back(make_blk(8'h90));
      start_frame(16'd16);
      wait_done("t6b");
      frame_check("t6b", 16, 8'h90, 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
